noekeon_round_engine: RTL

- Iterative Noekeon datapath that runs the 16 full rounds, one per clock.
- Each round is: round-constant injection, Theta, Pi1, Gamma, Pi2.
- When the rounds finish, the block presents the final state, working key and final round constant to the downstream last-round stage (Theta plus constant XOR), which is combinational.
- Owns the 128-bit state register, the round counter, the round-constant generator and the load/result handshake.

---
 rtl/noekeon_round_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/noekeon_round_engine.sv
// Iterative Noekeon round engine: 16 full rounds (one per clock) feeding a combinational last-round stage.
// Build option NOEKEON_UNROLL2_EN chains two rounds per clock.
module noekeon_round_engine #(
  parameter int          ROUNDS      = 16,
  parameter logic [7:0]  RC_INIT_ENC = 8'h80,
  parameter logic [7:0]  RC_INIT_DEC = 8'hD4
) (
  input  logic         inClk,
  input  logic         inReset,
  input  logic         inStart,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  input  logic         inDecipher,
  output logic         outBusy,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outData,
  output logic [127:0] outKey,
  output logic [7:0]   outRoundconst,
  output logic         outDecipher,
  output logic [1:0]   dbg_state
);

`ifdef NOEKEON_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - STEP);
  localparam logic [CW-1:0] CNT_STEP = CW'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          load_en, round_en;
  logic [127:0]  data_q, key_q;
  logic [7:0]    rc_q;
  logic          dec_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  round1, data_nx;
  logic [7:0]    rc1, rc_nx;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = s[31:0];
    a1 = s[63:32];
    a2 = s[95:64];
    a3 = s[127:96];
    t  = a0 ^ a2;
    t  = t ^ rotr(t, 8) ^ rotl(t, 8);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[31:0];
    a1 = a1 ^ k[63:32];
    a2 = a2 ^ k[95:64];
    a3 = a3 ^ k[127:96];
    t  = a1 ^ a3;
    t  = t ^ rotr(t, 8) ^ rotl(t, 8);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {rotl(s[127:96], 2), rotl(s[95:64], 5), rotl(s[63:32], 1), s[31:0]};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {rotr(s[127:96], 2), rotr(s[95:64], 5), rotr(s[63:32], 1), s[31:0]};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = s[31:0];
    a1 = s[63:32];
    a2 = s[95:64];
    a3 = s[127:96];
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a0;
    a0 = a3;
    a3 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a3, a2, a1, a0};
  endfunction

  // Encryption injects the constant before Theta, decryption after it.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic [7:0] rc, input logic dec);
    logic [127:0] x;
    x = s;
    if (!dec) x[7:0] = x[7:0] ^ rc;
    x = theta(x, k);
    if (dec) x[7:0] = x[7:0] ^ rc;
    return pi2(gamma(pi1(x)));
  endfunction

  function automatic logic [7:0] rc_step(input logic [7:0] rc, input logic dec);
    logic [7:0] fwd, bwd, tmp;
    fwd = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    tmp = rc ^ 8'h1B;
    bwd = rc[0] ? {1'b1, tmp[7:1]} : {1'b0, rc[7:1]};
    return dec ? bwd : fwd;
  endfunction

  always_comb begin
    round1 = round_fn(data_q, key_q, rc_q, dec_q);
    rc1    = rc_step(rc_q, dec_q);
`ifdef NOEKEON_UNROLL2_EN
    data_nx = round_fn(round1, key_q, rc1, dec_q);
    rc_nx   = rc_step(rc1, dec_q);
`else
    data_nx = round1;
    rc_nx   = rc1;
`endif
  end

  // Handshake: inStart is taken only in IDLE (outBusy=0, outValid=0) and is never queued;
  // outValid stays high with all outputs frozen until a cycle with inReady=1, after which
  // the engine is IDLE on the next edge. inReady outside DONE has no effect.
  always_ff @(posedge inClk) begin
    if (inReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    round_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (inStart) begin
          load_en = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        round_en = 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (inReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inReset) begin
      data_q <= '0;
      key_q  <= '0;
      rc_q   <= '0;
      dec_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_en) begin
      data_q <= inData;
      key_q  <= inKey;
      dec_q  <= inDecipher;
      rc_q   <= inDecipher ? RC_INIT_DEC : RC_INIT_ENC;
      cnt_q  <= '0;
    end else if (round_en) begin
      data_q <= data_nx;
      rc_q   <= rc_nx;
      cnt_q  <= cnt_q + CNT_STEP;
    end
  end

  assign outBusy       = (state_q == RUN);
  assign outValid      = (state_q == DONE);
  assign outData       = data_q;
  assign outKey        = key_q;
  assign outRoundconst = rc_q;
  assign outDecipher   = dec_q;
  assign dbg_state     = state_q;

endmodule
